// File: rtl/scroll_ctrl.sv
// Scrolling-display sequencer: message store, scan/step tick generation, window-offset FSM and digit fetch.
// Build option SCROLL_HOLD_BLINK_EN: blank blinks at 2 Hz while in HOLD.
module scroll_ctrl #(
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 1000,
    parameter int MSG_DEPTH  = 16,
    parameter int NUM_DIGITS = 8,
    parameter int CHAR_W     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         dir,
    input  logic [1:0]                   speed,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic [CHAR_W-1:0]            digit_code,
    output logic                         blank,
    output logic [$clog2(MSG_DEPTH)-1:0] offset,
    output logic [1:0]                   state,
    output logic                         wrap_pulse
);
    localparam int AW       = $clog2(MSG_DEPTH);
    localparam int LW       = AW + 1;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SIW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STW      = $clog2(CLK_HZ);
    localparam int IW       = AW + SIW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t               st_q, st_d;
    logic                 go;
    logic [LW-1:0]        len_c;
    logic [SCW-1:0]       scan_cnt;
    logic [SIW-1:0]       scan_idx;
    logic                 scan_tick;
    logic [STW-1:0]       step_cnt, step_term;
    logic [1:0]           speed_q;
    logic                 step_clr, step_tick;
    logic [AW-1:0]        off_q;
    logic [IW-1:0]        idx;
    logic [CHAR_W-1:0]    mem [MSG_DEPTH];

    assign len_c  = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    assign offset = off_q;
    assign state  = st_q;

    assign scan_tick = (scan_cnt == SCW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == SIW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        step_term = STW'(CLK_HZ - 1);
        case (speed)
            2'd0:    step_term = STW'(CLK_HZ - 1);
            2'd1:    step_term = STW'(CLK_HZ / 2 - 1);
            2'd2:    step_term = STW'(CLK_HZ / 4 - 1);
            default: step_term = STW'(CLK_HZ / 8 - 1);
        endcase
    end

    // A rate change restarts the current step period rather than cutting it short.
    assign step_clr  = (st_q != ST_RUN) || (speed != speed_q);
    assign step_tick = !step_clr && (step_cnt == step_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            speed_q  <= '0;
        end else begin
            speed_q <= speed;
            if (step_clr || step_tick)
                step_cnt <= '0;
            else
                step_cnt <= step_cnt + 1'b1;
        end
    end

    always_comb begin
        st_d = st_q;
        go   = 1'b0;
        case (st_q)
            ST_IDLE: if (!stop && start && len_c != '0) begin
                st_d = ST_RUN;
                go   = 1'b1;
            end
            ST_RUN:  if (stop || len_c == '0) st_d = ST_IDLE;
                     else if (pause)          st_d = ST_HOLD;
            ST_HOLD: if (stop || len_c == '0) st_d = ST_IDLE;
                     else if (pause)          st_d = ST_RUN;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (go) begin
                off_q <= '0;
            end else if (LW'(off_q) >= len_c) begin
                // message shrank under the window: silently restart at 0
                off_q <= '0;
            end else if (step_tick) begin
                if (!dir) begin
                    if (LW'(off_q) == len_c - 1'b1) begin
                        off_q      <= '0;
                        wrap_pulse <= 1'b1;
                    end else begin
                        off_q <= off_q + 1'b1;
                    end
                end else if (off_q == '0) begin
                    off_q      <= AW'(len_c - 1'b1);
                    wrap_pulse <= 1'b1;
                end else begin
                    off_q <= off_q - 1'b1;
                end
            end
        end
    end

    // offset < len_c, so NUM_DIGITS conditional subtracts always reduce the sum below len_c
    always_comb begin
        idx = IW'(off_q) + IW'(scan_idx);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (len_c != '0 && idx >= IW'(len_c))
                idx = idx - IW'(len_c);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel  <= ~NUM_DIGITS'(1);
            digit_code <= '0;
        end else begin
            digit_sel  <= ~(NUM_DIGITS'(1) << scan_idx);
            digit_code <= (len_c == '0) ? '0 : mem[idx[AW-1:0]];
        end
    end

`ifdef SCROLL_HOLD_BLINK_EN
    localparam int HALF = CLK_HZ / 4;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (st_q != ST_HOLD) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank = (st_q == ST_IDLE) || ((st_q == ST_HOLD) && blink_q);
`else
    assign blank = (st_q == ST_IDLE);
`endif

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: directed sequence with randomized message contents, lengths and directions,
// checked against an arithmetic model of window offset, step timing and digit fetch.
module tb_scroll_ctrl;
    localparam int CLK_HZ  = 1600;
    localparam int SCAN_HZ = 100;
    localparam int DEPTH   = 16;
    localparam int ND      = 8;
    localparam int SLOT    = CLK_HZ / SCAN_HZ;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [4:0] msg_len = '0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0;
    logic [1:0] speed = 2'd2;
    logic [7:0] digit_sel;
    logic [4:0] digit_code;
    logic       blank;
    logic [3:0] offset;
    logic [1:0] state;
    logic       wrap_pulse;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [4:0] mem_m [DEPTH];

    scroll_ctrl #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MSG_DEPTH(DEPTH), .NUM_DIGITS(ND), .CHAR_W(5)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .speed(speed), .digit_sel(digit_sel), .digit_code(digit_code), .blank(blank),
        .offset(offset), .state(state), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    // posedges since reset release; the scan position follows from this alone
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit p_start, input bit p_stop, input bit p_pause);
        start = p_start; stop = p_stop; pause = p_pause;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 5'(d);
        mem_m[a] = 5'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_step(input int budget, output int at, output int wraps);
        logic [3:0] prev;
        prev  = offset;
        wraps = 0;
        at    = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wrap_pulse) wraps++;
            if (offset !== prev) begin
                at = cyc;
                break;
            end
        end
        check("step_seen", (at >= 0), 1);
    endtask

    task automatic run_steps(input int nsteps, input int len, input bit d, input int per,
                             inout int off, inout int t_ref);
        int at, wr, exp_off, exp_wrap;
        for (int k = 0; k < nsteps; k++) begin
            exp_off  = d ? (off + len - 1) % len : (off + 1) % len;
            exp_wrap = d ? (off == 0) : (exp_off == 0);
            wait_step(per + 50, at, wr);
            check("step_interval", at - t_ref, per);
            check("offset", offset, exp_off);
            check("wrap_count", wr, exp_wrap);
            off   = exp_off;
            t_ref = at;
        end
    endtask

    task automatic check_display(input int off, input int len, input int want_slot);
        int slot;
        bit found;
        logic [7:0] sel_exp;
        found = 1'b0;
        slot  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            slot = ((cyc - 1) / SLOT) % ND;
            if (slot == want_slot) begin
                found = 1'b1;
                break;
            end
        end
        check("slot_reached", found, 1);
        sel_exp = 8'hFF ^ (8'h01 << want_slot);
        check("digit_sel", digit_sel, sel_exp);
        check("digit_code", digit_code, mem_m[(off + want_slot) % len]);
    endtask

    initial begin
        int off, tref, len, a, blank_exp, s;
        #1 rst = 1'b1;
        #5;
        check("rst_state", state, 0);
        check("rst_blank", blank, 1);
        check("rst_sel", digit_sel, 8'hFE);
        check("rst_code", digit_code, 0);
        check("rst_offset", offset, 0);
        check("rst_wrap", wrap_pulse, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            write(i, (i < 10) ? i : int'($urandom_range(0, 31)));

        // empty message: start must be ignored
        msg_len = 5'd0;
        pulse(1, 0, 0);
        step_n(3);
        check("len0_state", state, 0);
        check("len0_blank", blank, 1);

        // forward scroll over 10 characters
        msg_len = 5'd10; dir = 1'b0; speed = 2'd2;
        pulse(1, 0, 0);
        tref = cyc; off = 0;
        check("fwd_state", state, 1);
        check("fwd_off0", offset, 0);
        check("run_blank", blank, 0);
        run_steps(8, 10, 0, 400, off, tref);
        check_display(off, 10, 3);
        run_steps(2, 10, 0, 400, off, tref);
        pulse(0, 1, 0);
        check("stop_state", state, 0);
        check("stop_blank", blank, 1);

        // reverse scroll
        dir = 1'b1;
        pulse(1, 0, 0);
        tref = cyc; off = 0;
        run_steps(2, 10, 1, 400, off, tref);

        // HOLD freezes the window for 2000 cycles
        pulse(0, 0, 1);
        check("hold_state", state, 2);
        for (int t = 0; t < 2000; t++) begin
            if (t % 100 == 0) begin
`ifdef SCROLL_HOLD_BLINK_EN
                blank_exp = (t / 400) % 2;
`else
                blank_exp = 0;
`endif
                check("hold_offset", offset, off);
                check("hold_blank", blank, blank_exp);
            end
            @(negedge clk);
        end
        pulse(0, 0, 1);
        check("resume_state", state, 1);
        tref = cyc;
        run_steps(1, 10, 1, 400, off, tref);
        check_display(off, 10, int'($urandom_range(0, ND - 1)));

        // stop wins over start in the same cycle
        pulse(1, 1, 0);
        check("stopstart_state", state, 0);
        check("stopstart_blank", blank, 1);

        // shrinking the message under the window
        dir = 1'b0;
        pulse(1, 0, 0);
        tref = cyc; off = 0;
        run_steps(7, 10, 0, 400, off, tref);
        step_n(5);
        msg_len = 5'd5;
        @(negedge clk);
        check("shrink_offset", offset, 0);
        check("shrink_wrap", wrap_pulse, 0);
        check("shrink_state", state, 1);
        @(negedge clk);
        check("shrink_wrap2", wrap_pulse, 0);
        off = 0;
        run_steps(1, 5, 0, 400, off, tref);

        // speed change restarts the step period at the new rate
        step_n(50);
        speed = 2'd3;
        @(negedge clk);
        tref = cyc;
        run_steps(2, 5, 0, 200, off, tref);

        // writes while running are visible on the next fetch
        s = int'($urandom_range(0, ND - 1));
        a = (off + s) % 5;
        write(a, int'($urandom_range(0, 31)));
        check_display(off, 5, s);

        // randomized length and direction
        pulse(0, 1, 0);
        len = int'($urandom_range(2, 16));
        for (int i = 0; i < DEPTH; i++)
            write(i, int'($urandom_range(0, 31)));
        msg_len = 5'(len);
        dir = 1'($urandom_range(0, 1));
        pulse(1, 0, 0);
        tref = cyc; off = 0;
        run_steps(len + 2, len, dir, 200, off, tref);
        check_display(off, len, int'($urandom_range(0, ND - 1)));

        // oversized length behaves as a full buffer
        pulse(0, 1, 0);
        msg_len = 5'd20; dir = 1'b0;
        pulse(1, 0, 0);
        tref = cyc; off = 0;
        run_steps(16, 16, 0, 200, off, tref);

        // message length dropping to zero returns to IDLE
        msg_len = 5'd0;
        @(negedge clk);
        check("len_zero_state", state, 0);
        check("len_zero_blank", blank, 1);

        // asynchronous reset in the middle of a run
        msg_len = 5'd10; speed = 2'd2;
        pulse(1, 0, 0);
        step_n(450);
        check("pre_rst_offset", offset, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_blank", blank, 1);
        check("arst_sel", digit_sel, 8'hFE);
        check("arst_offset", offset, 0);
        check("arst_code", digit_code, 0);
        check("arst_wrap", wrap_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Sequencer for the 8-digit scrolling display.
- Stores a message of up to MSG_DEPTH character codes and generates two single-cycle tick enables from clk: a scan tick and a selectable-rate step tick. No derived clocks.
- Steps a circular window offset through the message and drives, per scan slot, a one-hot digit select plus the character code for that digit.
- Sits between the host/keypad logic (message writes, run control) and the 7-segment decoder.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz; one scan slot lasts CLK_HZ/SCAN_HZ cycles.
- MSG_DEPTH, 16, message buffer entries; power of two.
- NUM_DIGITS, 8, display digits.
- CHAR_W, 5, character code width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  message write strobe
- wr_addr  in  log2(MSG_DEPTH)  write address
- wr_data  in  CHAR_W  character code to write
- msg_len  in  log2(MSG_DEPTH)+1  active message length, 0..MSG_DEPTH
- start  in  1  start-scroll pulse
- stop  in  1  stop pulse
- pause  in  1  toggle RUN/HOLD pulse
- dir  in  1  0 = offset increments (text moves left); 1 = offset decrements
- speed  in  2  step rate: 0=1 Hz, 1=2 Hz, 2=4 Hz, 3=8 Hz
- digit_sel  out  NUM_DIGITS  one-hot, active-low digit enable
- digit_code  out  CHAR_W  code for the selected digit
- blank  out  1  1 = decoder drives all segments off
- offset  out  log2(MSG_DEPTH)  current window start
- state  out  2  00=IDLE, 01=RUN, 10=HOLD
- wrap_pulse  out  1  one-cycle pulse when offset wraps

Behaviour:
- Reset values: state IDLE, offset 0, scan index 0, digit_sel = all ones except bit0 low, digit_code 0, blank 1, wrap_pulse 0, all counters 0. Message memory is not reset.
- Scan tick: counter runs 0..CLK_HZ/SCAN_HZ-1 and asserts the tick for one cycle on the terminal count.
  - Scan index advances 0..NUM_DIGITS-1 and wraps. Scan runs in every state.
- Step tick: counter runs 0..CLK_HZ/rate-1, with rate taken from speed.
  - Counter clears on any change of speed and whenever state is not RUN.
- FSM (priority stop > start > pause):
  - IDLE: start with msg_len != 0 -> RUN, offset cleared. Start with msg_len == 0 is ignored.
  - RUN: stop -> IDLE. Pause -> HOLD. Step tick moves offset by ±1 modulo msg_len.
  - HOLD: stop -> IDLE. Pause -> RUN with the step counter cleared. Offset is frozen. Start has no effect.
  - RUN/HOLD with msg_len becoming 0 -> IDLE on the next cycle.
- Offset arithmetic:
  - Forward: offset == msg_len-1 -> 0.
  - Reverse: offset == 0 -> msg_len-1.
  - wrap_pulse asserts for one cycle on either wrap.
  - If msg_len shrinks so that offset >= msg_len, offset forces to 0 the next cycle and wrap_pulse does not assert.
- Fetch: character index = (offset + scan index) mod msg_len, computed without a divider (conditional subtract; msg_len <= MSG_DEPTH).
  - digit_code and digit_sel are registered and update together 1 cycle after the scan index changes.
  - blank = 1 in IDLE, 0 in RUN/HOLD.
- Writes: accepted in any state.
  - A write takes effect on the next fetch of that address.
  - Writing during the fetch cycle of the same address returns the old data (read-before-write).
- msg_len > MSG_DEPTH is clamped to MSG_DEPTH.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: SCROLL_HOLD_BLINK_EN.
- Defined: in HOLD, blank toggles at 2 Hz from an internal half-period counter (CLK_HZ/4 cycles), starting at 0 on entry to HOLD. RUN and IDLE are unaffected.
- Undefined: blank is 0 throughout HOLD, and the blink counter is not built.

Test Plan:
- All scenarios use CLK_HZ=1600, SCAN_HZ=100, speed=2, so a scan slot is 16 cycles and a step is 400 cycles.
- Reset: rst high mid-RUN -> state=00, blank=1, digit_sel=8'hFE, offset=0 in the same cycle.
- Forward scroll: write codes 0..9, msg_len=10, dir=0, start -> offset 0,1,...,9,0 at 400-cycle intervals; wrap_pulse exactly once at 9->0. In slot 3 at offset 8, digit_code = 1 with digit_sel=8'hF7.
- Reverse scroll: dir=1, msg_len=10, start -> offset 0,9,8; wrap_pulse at 0->9.
- Pause/stop priority: pause in RUN -> HOLD, offset frozen for 2000 cycles. Stop and start pulsed in the same cycle -> IDLE, blank=1.
- Boundaries:
  - msg_len=0 then start -> stays IDLE.
  - In RUN at offset 7, msg_len changed to 5 -> offset=0 next cycle, no wrap_pulse.
  - speed changed 2->3 -> next step 200 cycles after the change.
- Optional feature (macro defined): in HOLD, blank toggles every 400 cycles starting at 0.
